reg_write_arbiter: RTL and testbench

Round-robin write-port arbiter and sequencer for a single n-bit `register_n` instance in the adder datapath. Four requesters (operand loaders, result writeback, test/debug port) share the register's `d`/`wr_en` inputs. A separate clear request drives the register's synchronous reset. The block supports locked multi-beat bursts with a bounded length, so no requester can starve the others.

---
 rtl/reg_write_arbiter.sv | 116 +++++++++++
 tb/tb_reg_write_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter/sequencer for one register_n: four writers share d/wr_en, plus a clear port.
// Latency: req in IDLE at cycle t -> grant and first write beat at t+1; one IDLE cycle between grants and after a clear.
// Backpressure: a waiting requester simply holds req; bursts are capped at MAX_BURST beats so nobody starves.
module reg_write_arbiter #(
  parameter int N         = 32,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     req,
  input  logic [3:0]     lock,
  input  logic [4*N-1:0] wdata,
  input  logic           clr_req,
  output logic [3:0]     grant,
  output logic           reg_wr_en,
  output logic [N-1:0]   reg_d,
  output logic           reg_clr,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Beat-counter value of the final beat allowed in one grant.
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     state;
  logic [1:0] owner;
  logic [1:0] ptr;
  logic [3:0] beat_cnt;

  logic [1:0] pick;
  logic       pick_vld;
  logic [1:0] scan_idx;
  logic       owner_req;
  logic       owner_lock;

  // Round-robin scan: first set req bit starting at ptr; descending loop so the nearest index wins.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    scan_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr + 2'(k);
      if (req[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_req  = req[owner];
  assign owner_lock = lock[owner];

  // Write port and clear are pure decodes of the registered state, so reset silences them immediately.
  always_comb begin
    reg_wr_en = (state == BUSY) && owner_req;
    reg_clr   = (state == CLEAR);
    busy      = (state != IDLE);
    reg_d     = '0;
    if (reg_wr_en) begin
      reg_d = wdata[int'(owner)*N +: N];
    end
  end

  // Arbitration FSM: grant, burst tracking, round-robin pointer and clear sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      beat_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
          end else if (pick_vld) begin
            state    <= BUSY;
            owner    <= pick;
            grant    <= 4'b0001 << pick;
            beat_cnt <= 4'd0;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            // Owner stopped writing: release without a beat.
            state <= IDLE;
            grant <= 4'b0000;
            ptr   <= owner + 2'd1;
          end else if (!owner_lock || beat_cnt == LAST_BEAT) begin
            // Unlocked single beat or burst cap reached: this beat writes, then release.
            state    <= IDLE;
            grant    <= 4'b0000;
            ptr      <= owner + 2'd1;
            beat_cnt <= beat_cnt + 4'd1;
          end else begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [3:0]     req;
  logic [3:0]     lock;
  logic [4*N-1:0] wdata;
  logic           clr_req;
  logic [3:0]     grant;
  logic           reg_wr_en;
  logic [N-1:0]   reg_d;
  logic           reg_clr;
  logic           busy;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_fair  [9];
  logic [3:0] exp_burst [7];

  reg_write_arbiter #(.N(N), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .lock      (lock),
    .wdata     (wdata),
    .clr_req   (clr_req),
    .grant     (grant),
    .reg_wr_en (reg_wr_en),
    .reg_d     (reg_d),
    .reg_clr   (reg_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    lock    = 4'b0000;
    clr_req = 1'b0;
    #1;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    req     = 4'b0000;
    lock    = 4'b0000;
    clr_req = 1'b0;
    #1;
    reset_n = 1'b0;
    #2;
    total++;
    if (grant !== 4'b0000 || reg_wr_en !== 1'b0 || reg_clr !== 1'b0 || busy !== 1'b0 || reg_d !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got grant=%b wr=%b clr=%b busy=%b d=%h want 0000/0/0/0/0", grant, reg_wr_en, reg_clr, busy, reg_d);
    end
    total++;
    if (dut.ptr !== 2'd0) begin
      bad++;
      $display("FAIL reset_ptr got=%0d want=0", dut.ptr);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got grant=%b busy=%b want 0000/0", grant, busy);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    req  = 4'b0010;
    lock = 4'b0000;
    tick();
    total++;
    if (grant !== 4'b0010 || reg_wr_en !== 1'b1 || reg_d !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_beat got grant=%b wr=%b d=%h want 0010/1/deadbeef", grant, reg_wr_en, reg_d);
    end
    tick();
    req = 4'b0000;
    #1;
    total++;
    if (grant !== 4'b0000 || reg_wr_en !== 1'b0 || reg_d !== 32'h0) begin
      bad++;
      $display("FAIL single_release got grant=%b wr=%b d=%h want 0000/0/0", grant, reg_wr_en, reg_d);
    end
    total++;
    if (dut.ptr !== 2'd2) begin
      bad++;
      $display("FAIL single_ptr got=%0d want=2", dut.ptr);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req  = 4'b1111;
    lock = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (grant !== exp_fair[i] || reg_wr_en !== (exp_fair[i] != 4'b0000)) begin
        bad++;
        $display("FAIL rr_step%0d got grant=%b wr=%b want grant=%b wr=%b", i, grant, reg_wr_en, exp_fair[i], exp_fair[i] != 4'b0000);
      end
    end
    total++;
    if (reg_d !== 32'hA0A0A0A0) begin
      bad++;
      $display("FAIL rr_wrap_data got=%h want=a0a0a0a0", reg_d);
    end
    req = 4'b0000;
  endtask

  task automatic test_burst_cap();
    do_reset();
    req  = 4'b0011;
    lock = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (grant !== exp_burst[i] || reg_wr_en !== (exp_burst[i] != 4'b0000)) begin
        bad++;
        $display("FAIL burst_step%0d got grant=%b wr=%b want grant=%b wr=%b", i, grant, reg_wr_en, exp_burst[i], exp_burst[i] != 4'b0000);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_early_release();
    // Owner 2 drops req on its second granted cycle.
    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    tick();
    total++;
    if (grant !== 4'b0100 || reg_wr_en !== 1'b1 || reg_d !== 32'hC2C2C2C2) begin
      bad++;
      $display("FAIL drop_req_beat1 got grant=%b wr=%b d=%h want 0100/1/c2c2c2c2", grant, reg_wr_en, reg_d);
    end
    tick();
    req = 4'b0000;
    #1;
    total++;
    if (grant !== 4'b0100 || reg_wr_en !== 1'b0 || reg_d !== 32'h0) begin
      bad++;
      $display("FAIL drop_req_nowrite got grant=%b wr=%b d=%h want 0100/0/0", grant, reg_wr_en, reg_d);
    end
    tick();
    total++;
    if (grant !== 4'b0000 || dut.ptr !== 2'd3) begin
      bad++;
      $display("FAIL drop_req_release got grant=%b ptr=%0d want 0000/3", grant, dut.ptr);
    end
    // Owner 2 drops lock on beat 2: that beat still writes.
    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    tick();
    tick();
    lock = 4'b0000;
    #1;
    total++;
    if (grant !== 4'b0100 || reg_wr_en !== 1'b1 || reg_d !== 32'hC2C2C2C2) begin
      bad++;
      $display("FAIL drop_lock_beat2 got grant=%b wr=%b d=%h want 0100/1/c2c2c2c2", grant, reg_wr_en, reg_d);
    end
    tick();
    req = 4'b0000;
    #1;
    total++;
    if (grant !== 4'b0000 || dut.ptr !== 2'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_lock_release got grant=%b ptr=%0d busy=%b want 0000/3/0", grant, dut.ptr, busy);
    end
  endtask

  task automatic test_clear();
    // Clear wins over a simultaneous request in IDLE.
    do_reset();
    clr_req = 1'b1;
    req     = 4'b0100;
    tick();
    total++;
    if (reg_clr !== 1'b1 || grant !== 4'b0000 || reg_wr_en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL clr_prio got clr=%b grant=%b wr=%b busy=%b want 1/0000/0/1", reg_clr, grant, reg_wr_en, busy);
    end
    clr_req = 1'b0;
    tick();
    total++;
    if (reg_clr !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clr_idle got clr=%b grant=%b busy=%b want 0/0000/0", reg_clr, grant, busy);
    end
    tick();
    total++;
    if (grant !== 4'b0100 || reg_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL clr_then_grant got grant=%b wr=%b want 0100/1", grant, reg_wr_en);
    end
    // Clear raised mid-burst waits for release plus an IDLE cycle.
    do_reset();
    req  = 4'b0001;
    lock = 4'b0001;
    tick();
    clr_req = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (grant !== 4'b0001 || reg_clr !== 1'b0 || reg_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL clr_midburst_beat4 got grant=%b clr=%b wr=%b want 0001/0/1", grant, reg_clr, reg_wr_en);
    end
    tick();
    total++;
    if (grant !== 4'b0000 || reg_clr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clr_midburst_idle got grant=%b clr=%b busy=%b want 0000/0/0", grant, reg_clr, busy);
    end
    tick();
    total++;
    if (reg_clr !== 1'b1 || reg_wr_en !== 1'b0 || grant !== 4'b0000) begin
      bad++;
      $display("FAIL clr_midburst_clear got clr=%b wr=%b grant=%b want 1/0/0000", reg_clr, reg_wr_en, grant);
    end
    clr_req = 1'b0;
    tick();
    tick();
    total++;
    if (grant !== 4'b0001 || reg_clr !== 1'b0) begin
      bad++;
      $display("FAIL clr_midburst_regrant got grant=%b clr=%b want 0001/0", grant, reg_clr);
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    // Owner 1 takes one cycle and releases so ptr moves off zero.
    req  = 4'b0010;
    lock = 4'b0000;
    tick();
    req  = 4'b0100;
    lock = 4'b0100;
    tick();
    tick();
    tick();
    total++;
    if (grant !== 4'b0100 || reg_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_beat2 got grant=%b wr=%b want 0100/1", grant, reg_wr_en);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (grant !== 4'b0000 || reg_wr_en !== 1'b0 || busy !== 1'b0 || reg_d !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_async got grant=%b wr=%b busy=%b d=%h want 0000/0/0/0", grant, reg_wr_en, busy, reg_d);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    req     = 4'b1111;
    lock    = 4'b0000;
    tick();
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL rst_mid_first_grant got=%b want=0001", grant);
    end
    req = 4'b0000;
  endtask

  initial begin
    exp_fair  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    exp_burst = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    wdata   = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hDEADBEEF, 32'hA0A0A0A0};
    reset_n = 1'b1;
    req     = 4'b0000;
    lock    = 4'b0000;
    clr_req = 1'b0;

    test_reset();
    test_single_write();
    test_round_robin();
    test_burst_cap();
    test_early_release();
    test_clear();
    test_reset_mid_burst();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
